// File: rtl/note_sequencer_if.sv
// Control, song-table write and tone-output bundle for note_sequencer.
// The sequencer takes the slave side; the controller or bench takes the master side.
interface note_sequencer_if #(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 4,
  parameter int SEL_W  = 3,
  parameter int IDX_W  = 3
);
  logic              start;
  logic [SEL_W-1:0]  song_sel;
  logic              loop_en;
  logic              stop;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_song;
  logic [IDX_W-1:0]  wr_idx;
  logic [NOTE_W-1:0] wr_note;
  logic [DUR_W-1:0]  wr_dur;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic [IDX_W-1:0]  note_idx;
  logic              busy;
  logic              seq_end;

  modport master (
    output start, song_sel, loop_en, stop, wr_en, wr_song, wr_idx, wr_note, wr_dur,
    input  note_out, note_valid, note_idx, busy, seq_end
  );

  modport slave (
    input  start, song_sel, loop_en, stop, wr_en, wr_song, wr_idx, wr_note, wr_dur,
    output note_out, note_valid, note_idx, busy, seq_end
  );
endinterface

// File: rtl/note_sequencer.sv
// Programmable tone sequencer: steps through a stored song table and drives note codes
// to the tone generator for duration x TICK_DIV clocks each, with loop, stop and pre-emption.
module note_sequencer #(
  parameter int NOTE_W    = 4,
  parameter int DUR_W     = 4,
  parameter int MAX_NOTES = 8,
  parameter int NUM_SONGS = 8,
  parameter int SEL_W     = 3,
  parameter int IDX_W     = 3,
  parameter int TICK_DIV  = 25000000,
  parameter int REST_CODE = 7,
  parameter int END_CODE  = 8,
  parameter int PREEMPT   = 1
) (
  input logic clk,
  input logic reset,
  note_sequencer_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MAX_NOTES - 1);
  localparam logic [NOTE_W-1:0] REST_V    = NOTE_W'(REST_CODE);
  localparam logic [NOTE_W-1:0] END_V     = NOTE_W'(END_CODE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  logic [NOTE_W-1:0] r_note_tab [NUM_SONGS][MAX_NOTES];
  logic [DUR_W-1:0]  r_dur_tab  [NUM_SONGS][MAX_NOTES];

  state_t            r_state;
  logic [SEL_W-1:0]  r_song;
  logic              r_loop;
  logic [IDX_W-1:0]  r_idx;
  logic [TICK_W-1:0] r_tick;
  logic [DUR_W-1:0]  r_dur_cnt;
  logic [NOTE_W-1:0] r_note;
  logic              r_valid;
  logic              r_busy;
  logic              r_seq_end;

  logic [NOTE_W-1:0] w_rd_note;
  logic [DUR_W-1:0]  w_rd_dur;
  logic              w_wr_ok;

  assign w_wr_ok = bus.wr_en && (int'(bus.wr_song) < NUM_SONGS) && (int'(bus.wr_idx) < MAX_NOTES);

  // Song table storage; a LOAD in the same cycle as a write sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SONGS; s++) begin
        for (int i = 0; i < MAX_NOTES; i++) begin
          r_note_tab[s][i] <= END_V;
          r_dur_tab[s][i]  <= {DUR_W{1'b0}};
        end
      end
    end else if (w_wr_ok) begin
      r_note_tab[bus.wr_song][bus.wr_idx] <= bus.wr_note;
      r_dur_tab[bus.wr_song][bus.wr_idx]  <= bus.wr_dur;
    end else begin
      r_note_tab[0][0] <= r_note_tab[0][0];
    end
  end

  // Entry read for LOAD; a song slot beyond the table reads as an empty song.
  always_comb begin
    w_rd_note = END_V;
    w_rd_dur  = {DUR_W{1'b0}};
    if ((int'(r_song) < NUM_SONGS) && (int'(r_idx) < MAX_NOTES)) begin
      w_rd_note = r_note_tab[r_song][r_idx];
      w_rd_dur  = r_dur_tab[r_song][r_idx];
    end else begin
      w_rd_note = END_V;
      w_rd_dur  = {DUR_W{1'b0}};
    end
  end

  // Playback state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_song    <= {SEL_W{1'b0}};
      r_loop    <= 1'b0;
      r_idx     <= {IDX_W{1'b0}};
      r_tick    <= {TICK_W{1'b0}};
      r_dur_cnt <= {DUR_W{1'b0}};
      r_note    <= REST_V;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_seq_end <= 1'b0;
    end else begin
      r_seq_end <= 1'b0;
      if ((r_state != S_IDLE) && bus.stop) begin
        r_state   <= S_IDLE;
        r_idx     <= {IDX_W{1'b0}};
        r_tick    <= {TICK_W{1'b0}};
        r_dur_cnt <= {DUR_W{1'b0}};
        r_note    <= REST_V;
        r_valid   <= 1'b0;
        r_busy    <= 1'b0;
      end else if (bus.start && !bus.stop && ((r_state == S_IDLE) || (PREEMPT != 0))) begin
        r_state   <= S_LOAD;
        r_song    <= bus.song_sel;
        r_loop    <= bus.loop_en;
        r_idx     <= {IDX_W{1'b0}};
        r_tick    <= {TICK_W{1'b0}};
        r_dur_cnt <= {DUR_W{1'b0}};
        r_note    <= REST_V;
        r_valid   <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_LOAD: begin
            if (w_rd_note == END_V) begin
              // END at index 0 always terminates so an empty looped song cannot spin.
              if (r_loop && (r_idx != {IDX_W{1'b0}})) begin
                r_idx <= {IDX_W{1'b0}};
              end else begin
                r_state <= S_IDLE;
                r_idx   <= {IDX_W{1'b0}};
                r_busy  <= 1'b0;
              end
              r_seq_end <= 1'b1;
            end else begin
              r_state   <= S_PLAY;
              r_note    <= w_rd_note;
              r_valid   <= 1'b1;
              r_tick    <= {TICK_W{1'b0}};
              r_dur_cnt <= (w_rd_dur == {DUR_W{1'b0}}) ? DUR_W'(1) : w_rd_dur;
            end
          end
          S_PLAY: begin
            if (r_tick == TICK_LAST) begin
              r_tick <= {TICK_W{1'b0}};
              if (r_dur_cnt <= DUR_W'(1)) begin
                r_state <= S_NEXT;
                r_note  <= REST_V;
                r_valid <= 1'b0;
              end else begin
                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
              end
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
          end
          S_NEXT: begin
            if (r_idx == IDX_LAST) begin
              if (r_loop) begin
                r_state <= S_LOAD;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
              r_idx     <= {IDX_W{1'b0}};
              r_seq_end <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_LOAD;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_note  <= REST_V;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.note_out   = r_note;
  assign bus.note_valid = r_valid;
  assign bus.note_idx   = r_idx;
  assign bus.busy       = r_busy;
  assign bus.seq_end    = r_seq_end;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (TICK_DIV = 4): vector table, directed corner
// sequences, and randomized songs compared against a trace-building reference model.
module tb_note_sequencer;

  localparam int TICK = 4;
  localparam int REST = 7;
  localparam int ENDC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       t_start, t_loop, t_stop, t_wr_en;
  logic [2:0] t_sel, t_wsong, t_widx;
  logic [3:0] t_wnote, t_wdur;

  int n_checks = 0;
  int n_err    = 0;

  int m_note [8][8];
  int m_dur  [8][8];
  logic [11:0] q[$];

  typedef struct {
    int note;
    int dur;
    int play;
    int seq_at;
  } vec_t;
  vec_t vt[6];

  note_sequencer_if bus0();
  note_sequencer_if bus1();

  assign bus0.start = t_start;  assign bus1.start = t_start;
  assign bus0.song_sel = t_sel; assign bus1.song_sel = t_sel;
  assign bus0.loop_en = t_loop; assign bus1.loop_en = t_loop;
  assign bus0.stop = t_stop;    assign bus1.stop = t_stop;
  assign bus0.wr_en = t_wr_en;  assign bus1.wr_en = t_wr_en;
  assign bus0.wr_song = t_wsong; assign bus1.wr_song = t_wsong;
  assign bus0.wr_idx = t_widx;  assign bus1.wr_idx = t_widx;
  assign bus0.wr_note = t_wnote; assign bus1.wr_note = t_wnote;
  assign bus0.wr_dur = t_wdur;  assign bus1.wr_dur = t_wdur;

  note_sequencer #(.TICK_DIV(TICK), .PREEMPT(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  note_sequencer #(.TICK_DIV(TICK), .PREEMPT(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pk(input int n, input bit v, input bit b, input bit e, input int i);
    return {4'(n), v, b, e, 3'(i)};
  endfunction

  function automatic logic [11:0] obs0();
    return {bus0.note_out, bus0.note_valid, bus0.busy, bus0.seq_end, bus0.note_idx};
  endfunction

  function automatic logic [11:0] obs1();
    return {bus1.note_out, bus1.note_valid, bus1.busy, bus1.seq_end, bus1.note_idx};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 8; i++) begin
        m_note[s][i] = ENDC;
        m_dur[s][i]  = 0;
      end
  endtask

  task automatic wr(input int s, input int i, input int n, input int d);
    t_wr_en = 1'b1; t_wsong = 3'(s); t_widx = 3'(i); t_wnote = 4'(n); t_wdur = 4'(d);
    step();
    t_wr_en = 1'b0;
    m_note[s][i] = n;
    m_dur[s][i]  = d;
  endtask

  // Expected per-cycle outputs from the cycle after start: LOAD, note*dur*TICK, NEXT, LOAD ...
  task automatic build(input int s, input bit lp, input int maxc);
    bit e_flag, done, wrap;
    int i, code, d;
    e_flag = 0; done = 0;
    q.delete();
    while (!done && q.size() < maxc) begin
      i = 0; wrap = 0;
      q.push_back(pk(REST, 0, 1, e_flag, 0));
      e_flag = 0;
      while (!done && !wrap) begin
        code = m_note[s][i];
        if (code == ENDC) begin
          if (lp && i != 0) wrap = 1; else done = 1;
        end else begin
          d = (m_dur[s][i] == 0) ? 1 : m_dur[s][i];
          repeat (d * TICK) q.push_back(pk(code, 1, 1, 0, i));
          q.push_back(pk(REST, 0, 1, 0, i));
          if (i == 7) begin
            if (lp) wrap = 1; else done = 1;
          end else begin
            i++;
            q.push_back(pk(REST, 0, 1, 0, i));
          end
        end
      end
      if (wrap) e_flag = 1;
    end
    if (done) begin
      q.push_back(pk(REST, 0, 0, 1, 0));
      q.push_back(pk(REST, 0, 0, 0, 0));
    end
  endtask

  task automatic run_trace(input string nm, input int n);
    for (int k = 0; k < n && k < q.size(); k++) begin
      step();
      if (k == 0) t_start = 1'b0;
      chk(nm, 32'(obs0()), 32'(q[k]));
    end
  endtask

  task automatic stop_and_check(input string nm);
    t_stop = 1'b1;
    step();
    t_stop = 1'b0;
    chk(nm, 32'(obs0()), 32'(pk(REST, 0, 0, 0, 0)));
    step();
    chk({nm, "_hold"}, 32'(obs0()), 32'(pk(REST, 0, 0, 0, 0)));
  endtask

  initial begin
    int play, seqc, c, len, lp, s;
    reset = 1'b1;
    t_start = 1'b0; t_loop = 1'b0; t_stop = 1'b0; t_wr_en = 1'b0;
    t_sel = 3'd0; t_wsong = 3'd0; t_widx = 3'd0; t_wnote = 4'd0; t_wdur = 4'd0;
    model_reset();
    repeat (3) step();
    chk("reset_dut0", 32'(obs0()), 32'(pk(REST, 0, 0, 0, 0)));
    chk("reset_dut1", 32'(obs1()), 32'(pk(REST, 0, 0, 0, 0)));
    reset = 1'b0;
    step();

    // Single-note songs: {note, dur, valid cycles, seq_end cycle}
    vt[0] = '{2, 1, 4, 8};
    vt[1] = '{7, 2, 8, 12};
    vt[2] = '{12, 3, 12, 16};
    vt[3] = '{5, 0, 4, 8};
    vt[4] = '{15, 15, 60, 64};
    vt[5] = '{0, 2, 8, 12};
    for (int r = 0; r < 6; r++) begin
      wr(4, 0, vt[r].note, vt[r].dur);
      wr(4, 1, ENDC, 0);
      t_sel = 3'd4; t_loop = 1'b0; t_start = 1'b1;
      play = 0; seqc = -1;
      for (int k = 1; k <= vt[r].seq_at + 3; k++) begin
        step();
        if (k == 1) t_start = 1'b0;
        if (k == 2) chk("vec_first_note", 32'(bus0.note_out), 32'(vt[r].note));
        if (bus0.note_valid) play++;
        if (bus0.seq_end && seqc < 0) seqc = k;
      end
      chk("vec_play_len", 32'(play), 32'(vt[r].play));
      chk("vec_seq_end_cycle", 32'(seqc), 32'(vt[r].seq_at));
    end

    // Basic song 2: C d1, E d2, END
    wr(2, 0, 2, 1); wr(2, 1, 4, 2); wr(2, 2, ENDC, 0);
    t_sel = 3'd2; t_loop = 1'b0; t_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) t_start = 1'b0;
      chk("basic_note", 32'(bus0.note_out), (k >= 2 && k <= 5) ? 32'd2 : (k >= 8 && k <= 15) ? 32'd4 : 32'd7);
      chk("basic_seq_end", 32'(bus0.seq_end), 32'(k == 18));
      chk("basic_busy", 32'(bus0.busy), 32'(k >= 1 && k <= 17));
    end

    // Looped song 2, then stop
    t_sel = 3'd2; t_loop = 1'b1; t_start = 1'b1;
    build(2, 1, 45);
    run_trace("loop_trace", q.size());
    stop_and_check("loop_stop");

    // Song 0 untouched since reset: END at index 0
    t_sel = 3'd0; t_loop = 1'b1; t_start = 1'b1;
    build(0, 1, 20);
    run_trace("empty_song", q.size());

    // Full 8-entry song without END
    for (int i = 0; i < 8; i++) wr(5, i, (i == 6) ? 9 : (i == 7) ? 10 : i + 1, i % 3);
    t_sel = 3'd5; t_loop = 1'b0; t_start = 1'b1;
    build(5, 0, 500);
    run_trace("full8", q.size());

    // Pre-emption: song 3 started during PLAY of song 2
    wr(3, 0, 3, 1); wr(3, 1, ENDC, 0);
    t_sel = 3'd2; t_loop = 1'b0; t_start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      step();
      if (k == 1) t_start = 1'b0;
      if (k == 9) begin t_start = 1'b1; t_sel = 3'd3; end
      if (k == 10) begin
        t_start = 1'b0;
        chk("preempt_load", 32'(obs0()), 32'(pk(REST, 0, 1, 0, 0)));
        chk("nopreempt_note", 32'(obs1()), 32'(pk(4, 1, 1, 0, 1)));
      end
      if (k == 11) chk("preempt_note", 32'(bus0.note_out), 32'd3);
      chk("preempt_seq_end", 32'(bus0.seq_end), 32'(k == 17));
      chk("nopreempt_seq_end", 32'(bus1.seq_end), 32'(k == 18));
    end

    // start and stop together while idle
    t_sel = 3'd2; t_start = 1'b1; t_stop = 1'b1;
    step();
    t_start = 1'b0; t_stop = 1'b0;
    chk("start_stop_busy0", 32'(bus0.busy), 32'd0);
    chk("start_stop_busy1", 32'(bus1.busy), 32'd0);
    step();
    chk("start_stop_idle", 32'(obs0()), 32'(pk(REST, 0, 0, 0, 0)));

    // Write to [2][1] in the cycle LOAD reads it
    t_sel = 3'd2; t_loop = 1'b1; t_start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 1) t_start = 1'b0;
      if (k == 7) begin
        t_wr_en = 1'b1; t_wsong = 3'd2; t_widx = 3'd1; t_wnote = 4'd6; t_wdur = 4'd2;
      end
      if (k == 8) begin
        t_wr_en = 1'b0;
        chk("collide_old_note", 32'(bus0.note_out), 32'd4);
      end
      if (k == 25) chk("collide_new_note", 32'(bus0.note_out), 32'd6);
    end
    m_note[2][1] = 6; m_dur[2][1] = 2;
    stop_and_check("collide_stop");

    // Reset mid-PLAY restores outputs and table
    t_sel = 3'd2; t_loop = 1'b0; t_start = 1'b1;
    step(); t_start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_dut0", 32'(obs0()), 32'(pk(REST, 0, 0, 0, 0)));
    chk("midreset_dut1", 32'(obs1()), 32'(pk(REST, 0, 0, 0, 0)));
    model_reset();
    t_sel = 3'd2; t_loop = 1'b0; t_start = 1'b1;
    build(2, 0, 20);
    run_trace("midreset_table", q.size());

    // Random songs against the trace model
    for (int it = 0; it < 8; it++) begin
      s   = $urandom_range(7, 0);
      len = $urandom_range(8, 0);
      lp  = $urandom_range(1, 0);
      for (int i = 0; i < len; i++) begin
        c = $urandom_range(15, 0);
        if (c == ENDC) c = 9;
        wr(s, i, c, $urandom_range(3, 0));
      end
      if (len < 8) wr(s, len, ENDC, $urandom_range(3, 0));
      t_sel = 3'(s); t_loop = lp[0]; t_start = 1'b1;
      build(s, lp[0], 120);
      run_trace("rand_trace", q.size());
      if (lp != 0) stop_and_check("rand_stop");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Parametrised, programmable tone sequencer for the game audio path. Song table lives in an internal register file written through a write port; each entry holds a note code and a duration. On `start` it steps through the selected song, drives a note code to the tone generator for duration × `TICK_DIV` clocks, and reports end-of-sequence. Adds per-note duration, looping, stop/abort and pre-emptive restart.

Parameters:
NOTE_W, 4, note code width
DUR_W, 4, duration field width, in ticks
MAX_NOTES, 8, entries per song
NUM_SONGS, 8, song slots
SEL_W, 3, song select width (≥ clog2 NUM_SONGS)
IDX_W, 3, entry index width (≥ clog2 MAX_NOTES)
TICK_DIV, 25000000, clocks per duration tick (bench uses 4)
REST_CODE, 7, silent note code
END_CODE, 8, end-of-song marker
PREEMPT, 1, 1 = `start` while busy restarts; 0 = ignored

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begin song `song_sel`
song_sel  in  SEL_W  song slot, sampled with `start`
loop_en  in  1  sampled with `start`; replay song at END
stop  in  1  abort playback
wr_en  in  1  write song entry
wr_song  in  SEL_W  write slot
wr_idx  in  IDX_W  write entry index
wr_note  in  NOTE_W  note code to write
wr_dur  in  DUR_W  duration to write
note_out  out  NOTE_W  current note code to tone generator
note_valid  out  1  high while a note or rest is sounding
note_idx  out  IDX_W  index of current entry
busy  out  1  high in any non-IDLE state
seq_end  out  1  one-cycle pulse at song completion

Behaviour:
- Reset (synchronous) sets:
  - state IDLE; `note_out` = REST_CODE; `note_valid`, `busy`, `seq_end` = 0; `note_idx` = 0.
  - every table entry to {END_CODE, 0}; tick and duration counters to 0.
- States: IDLE, LOAD, PLAY, NEXT. All outputs are registered.
- IDLE + `start` (and not `stop`): latch `song_sel` and `loop_en`, set index = 0, go to LOAD.
- LOAD (1 cycle): read entry[song][index].
  - Code == END_CODE, loop latched and index ≠ 0: index = 0, stay in LOAD path; `seq_end` pulses the next cycle; `busy` stays high.
  - Code == END_CODE otherwise: go to IDLE; `seq_end` = 1 in the first IDLE cycle. END at index 0 always terminates, which prevents a livelock loop on an empty song.
  - Any other code: go to PLAY and load the duration counter with `dur`. `dur` = 0 is treated as 1.
- PLAY:
  - `note_out` = entry code and `note_valid` = 1 for exactly `dur` × TICK_DIV cycles.
  - REST_CODE entries play as timed silence with `note_valid` = 1.
  - Codes above END_CODE are passed through unchanged.
  - Then go to NEXT.
- NEXT (1 cycle):
  - If index == MAX_NOTES-1, handle exactly as END read in LOAD, no wrap of the index.
  - Otherwise index + 1, go to LOAD.
- Outside PLAY: `note_out` = REST_CODE, `note_valid` = 0. Gap between consecutive notes is 2 cycles (NEXT, LOAD).
- Latency: `start` sampled in cycle n → LOAD in n+1 → first note on `note_out` in n+2.
- `stop` in any non-IDLE state:
  - Next cycle IDLE with outputs at reset values; no `seq_end`. Table untouched.
  - `stop` and `start` in the same cycle: `stop` wins.
- `start` while busy:
  - PREEMPT = 1: abort the current song, latch new `song_sel`/`loop_en`, go to LOAD index 0; no `seq_end` for the aborted song.
  - PREEMPT = 0: ignored.
- Writes:
  - Accepted in any state, take effect at the clock edge.
  - A LOAD reading the entry written in the same cycle sees the old value.
  - Out-of-range `wr_song` (≥ NUM_SONGS) is ignored.
- Out-of-range `song_sel` behaves as an empty song: LOAD → IDLE, `seq_end` pulse.
- Tick counter counts 0..TICK_DIV-1 and only runs in PLAY; it clears on entry to PLAY.

Test Plan:
- Basic song (TICK_DIV=4): write song 2 = {C(2),d1},{E(4),d2},{END}; `start` at cycle 0 → `note_out`=2 cycles 2–5; rest cycles 6–7; `note_out`=4 cycles 8–15; `seq_end`=1 only at cycle 18; `busy` high cycles 1–17.
- Loop: same song with `loop_en`=1 → `seq_end` pulse after each pass, `busy` never drops, second pass `note_out`=2; assert `stop` → IDLE next cycle, `note_out`=7, no `seq_end`.
- Edge entries: song 0 entry 0 = END → `seq_end` at cycle 2, `note_valid` never high; `dur`=0 entry plays exactly 4 cycles; full 8-entry song without END ends after index 7 with `seq_end`.
- Pre-emption: PREEMPT=1, `start` song 3 during PLAY of song 2 → LOAD index 0 of song 3 next cycle, no `seq_end`; PREEMPT=0 → song 2 completes unchanged. `start` with `stop` in the same cycle → stays IDLE.
- Write/read collision: write entry [2][1] in the same cycle LOAD reads it → old note plays; the next pass plays the new note. `reset` mid-PLAY → all outputs at reset values next cycle, table back to END.
